// File: rtl/mempool_pkg.sv
// Shared MemPool TCDM types plus the per-bank owner encoding used by the tile bank arbiter.
package mempool_pkg;

  localparam int unsigned BankingFactor = 4;
  localparam int unsigned TcdmAddrWidth = 10;
  localparam int unsigned DataWidth     = 32;
  localparam int unsigned BeWidth       = DataWidth / 8;

  typedef logic [TcdmAddrWidth-1:0] tcdm_addr_t;
  typedef logic [DataWidth-1:0]     data_t;
  typedef logic [BeWidth-1:0]       be_t;

  typedef enum logic {BankOwnerLocal, BankOwnerRemote} bank_owner_e;

endpackage

// File: rtl/tile_bank_arb_2to1.sv
// One TCDM bank: 2:1 round-robin arbiter with same-cycle grant and 1-cycle response routing.
// Optional conflict counter enabled by `define TILE_BANK_ARB_PERF_EN.
module tile_bank_arb_2to1
  import mempool_pkg::*;
#(
  parameter int unsigned CntWidth = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                loc_req_i,
  input  tcdm_addr_t          loc_addr_i,
  input  logic                loc_wen_i,
  input  data_t               loc_wdata_i,
  input  be_t                 loc_be_i,
  output logic                loc_gnt_o,
  output logic                loc_vld_o,
  output data_t               loc_rdata_o,
  input  logic                rem_req_i,
  input  tcdm_addr_t          rem_addr_i,
  input  logic                rem_wen_i,
  input  data_t               rem_wdata_i,
  input  be_t                 rem_be_i,
  output logic                rem_gnt_o,
  output logic                rem_vld_o,
  output data_t               rem_rdata_o,
  output logic                mem_req_o,
  output tcdm_addr_t          mem_addr_o,
  output logic                mem_wen_o,
  output data_t               mem_wdata_o,
  output be_t                 mem_be_o,
  input  data_t               mem_rdata_i,
  input  logic                cnt_clr_i,
  output logic [CntWidth-1:0] conflict_cnt_o
);

  bank_owner_e prio_q, prio_d;
  bank_owner_e resp_own_q, resp_own_d;
  bank_owner_e winner;
  logic        resp_vld_q, resp_vld_d;
  logic        conflict;

  always_comb begin
    conflict = loc_req_i & rem_req_i;
    winner   = BankOwnerLocal;
    if (conflict) begin
      winner = prio_q;
    end else if (rem_req_i) begin
      winner = BankOwnerRemote;
    end

    // Loser of a conflict gets priority next time; quiet cycles leave it alone.
    prio_d = prio_q;
    if (conflict) begin
      prio_d = (prio_q == BankOwnerLocal) ? BankOwnerRemote : BankOwnerLocal;
    end

    loc_gnt_o = rst_ni & loc_req_i & (winner == BankOwnerLocal);
    rem_gnt_o = rst_ni & rem_req_i & (winner == BankOwnerRemote);

    mem_req_o   = loc_req_i | rem_req_i;
    mem_addr_o  = '0;
    mem_wen_o   = 1'b0;
    mem_wdata_o = '0;
    mem_be_o    = '0;
    if (mem_req_o) begin
      if (winner == BankOwnerLocal) begin
        mem_addr_o  = loc_addr_i;
        mem_wen_o   = loc_wen_i;
        mem_wdata_o = loc_wdata_i;
        mem_be_o    = loc_be_i;
      end else begin
        mem_addr_o  = rem_addr_i;
        mem_wen_o   = rem_wen_i;
        mem_wdata_o = rem_wdata_i;
        mem_be_o    = rem_be_i;
      end
    end

    resp_vld_d = mem_req_o;
    resp_own_d = winner;

    loc_vld_o   = resp_vld_q & (resp_own_q == BankOwnerLocal);
    rem_vld_o   = resp_vld_q & (resp_own_q == BankOwnerRemote);
    loc_rdata_o = loc_vld_o ? mem_rdata_i : '0;
    rem_rdata_o = rem_vld_o ? mem_rdata_i : '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prio_q     <= BankOwnerLocal;
      resp_vld_q <= 1'b0;
      resp_own_q <= BankOwnerLocal;
    end else begin
      prio_q     <= prio_d;
      resp_vld_q <= resp_vld_d;
      resp_own_q <= resp_own_d;
    end
  end

`ifdef TILE_BANK_ARB_PERF_EN
  logic [CntWidth-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr_i) begin
      cnt_d = '0;
    end else if (conflict && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign conflict_cnt_o = cnt_q;
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr_i;
  assign conflict_cnt_o = '0;
`endif

endmodule

// File: rtl/tile_bank_arbiter.sv
// Per-bank local/remote TCDM arbitration for a tile; fans ports out to one 2:1 arbiter per bank.
// Conflict counters present only with `define TILE_BANK_ARB_PERF_EN.
module tile_bank_arbiter
  import mempool_pkg::*;
#(
  parameter int unsigned NumBanks = BankingFactor,
  parameter int unsigned CntWidth = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [NumBanks-1:0] loc_req_i,
  input  tcdm_addr_t          loc_addr_i     [NumBanks],
  input  logic [NumBanks-1:0] loc_wen_i,
  input  data_t               loc_wdata_i    [NumBanks],
  input  be_t                 loc_be_i       [NumBanks],
  output logic [NumBanks-1:0] loc_gnt_o,
  output logic [NumBanks-1:0] loc_vld_o,
  output data_t               loc_rdata_o    [NumBanks],
  input  logic [NumBanks-1:0] rem_req_i,
  input  tcdm_addr_t          rem_addr_i     [NumBanks],
  input  logic [NumBanks-1:0] rem_wen_i,
  input  data_t               rem_wdata_i    [NumBanks],
  input  be_t                 rem_be_i       [NumBanks],
  output logic [NumBanks-1:0] rem_gnt_o,
  output logic [NumBanks-1:0] rem_vld_o,
  output data_t               rem_rdata_o    [NumBanks],
  output logic [NumBanks-1:0] mem_req_o,
  output tcdm_addr_t          mem_addr_o     [NumBanks],
  output logic [NumBanks-1:0] mem_wen_o,
  output data_t               mem_wdata_o    [NumBanks],
  output be_t                 mem_be_o       [NumBanks],
  input  data_t               mem_rdata_i    [NumBanks],
  input  logic                cnt_clr_i,
  output logic [CntWidth-1:0] conflict_cnt_o [NumBanks]
);

  for (genvar b = 0; b < NumBanks; b++) begin : gen_bank
    tile_bank_arb_2to1 #(
      .CntWidth(CntWidth)
    ) i_bank_arb (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .loc_req_i     (loc_req_i[b]),
      .loc_addr_i    (loc_addr_i[b]),
      .loc_wen_i     (loc_wen_i[b]),
      .loc_wdata_i   (loc_wdata_i[b]),
      .loc_be_i      (loc_be_i[b]),
      .loc_gnt_o     (loc_gnt_o[b]),
      .loc_vld_o     (loc_vld_o[b]),
      .loc_rdata_o   (loc_rdata_o[b]),
      .rem_req_i     (rem_req_i[b]),
      .rem_addr_i    (rem_addr_i[b]),
      .rem_wen_i     (rem_wen_i[b]),
      .rem_wdata_i   (rem_wdata_i[b]),
      .rem_be_i      (rem_be_i[b]),
      .rem_gnt_o     (rem_gnt_o[b]),
      .rem_vld_o     (rem_vld_o[b]),
      .rem_rdata_o   (rem_rdata_o[b]),
      .mem_req_o     (mem_req_o[b]),
      .mem_addr_o    (mem_addr_o[b]),
      .mem_wen_o     (mem_wen_o[b]),
      .mem_wdata_o   (mem_wdata_o[b]),
      .mem_be_o      (mem_be_o[b]),
      .mem_rdata_i   (mem_rdata_i[b]),
      .cnt_clr_i     (cnt_clr_i),
      .conflict_cnt_o(conflict_cnt_o[b])
    );
  end

endmodule

// File: tb/tb_tile_bank_arbiter.sv
// Self-checking bench for tile_bank_arbiter: directed scenarios plus randomized traffic vs a reference model.
module tb_tile_bank_arbiter;
  import mempool_pkg::*;

  localparam int unsigned NB     = BankingFactor;
  localparam int unsigned CW     = 4;
  localparam int unsigned CntMax = (1 << CW) - 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NB-1:0]     loc_req, loc_wen, loc_gnt, loc_vld;
  logic [NB-1:0]     rem_req, rem_wen, rem_gnt, rem_vld;
  logic [NB-1:0]     mem_req, mem_wen;
  tcdm_addr_t        loc_addr [NB], rem_addr [NB], mem_addr [NB];
  data_t             loc_wdata [NB], rem_wdata [NB], mem_wdata [NB];
  data_t             loc_rdata [NB], rem_rdata [NB], mem_rdata [NB];
  be_t               loc_be [NB], rem_be [NB], mem_be [NB];
  logic              cnt_clr;
  logic [CW-1:0]     cnt [NB];

  tile_bank_arbiter #(
    .NumBanks(NB),
    .CntWidth(CW)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .loc_req_i     (loc_req),
    .loc_addr_i    (loc_addr),
    .loc_wen_i     (loc_wen),
    .loc_wdata_i   (loc_wdata),
    .loc_be_i      (loc_be),
    .loc_gnt_o     (loc_gnt),
    .loc_vld_o     (loc_vld),
    .loc_rdata_o   (loc_rdata),
    .rem_req_i     (rem_req),
    .rem_addr_i    (rem_addr),
    .rem_wen_i     (rem_wen),
    .rem_wdata_i   (rem_wdata),
    .rem_be_i      (rem_be),
    .rem_gnt_o     (rem_gnt),
    .rem_vld_o     (rem_vld),
    .rem_rdata_o   (rem_rdata),
    .mem_req_o     (mem_req),
    .mem_addr_o    (mem_addr),
    .mem_wen_o     (mem_wen),
    .mem_wdata_o   (mem_wdata),
    .mem_be_o      (mem_be),
    .mem_rdata_i   (mem_rdata),
    .cnt_clr_i     (cnt_clr),
    .conflict_cnt_o(cnt)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Reference model state: pending (ungranted) requests with their held payload,
  // in-flight response owner, who won the last conflict, and conflict counts.
  bit          l_pend [NB], r_pend [NB];
  tcdm_addr_t  la [NB], ra [NB];
  logic        lw [NB], rw [NB];
  data_t       ld [NB], rd [NB];
  be_t         lb [NB], rb [NB];
  bit          rsp_v [NB], rsp_loc [NB];
  bit          last_loc_won [NB];
  int unsigned mcnt [NB];
  logic [NB-1:0] last_lg, last_rg;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] exp_cnt(input int unsigned m);
`ifdef TILE_BANK_ARB_PERF_EN
    return 64'(m);
`else
    return 64'(m & 0);
`endif
  endfunction

  task automatic model_clear();
    for (int b = 0; b < NB; b++) begin
      l_pend[b] = 0; r_pend[b] = 0;
      rsp_v[b] = 0; rsp_loc[b] = 0;
      last_loc_won[b] = 0;
      mcnt[b] = 0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n   = 1'b0;
    loc_req = '1;
    rem_req = '1;
    #1;
    check("rst_gnt", 64'({loc_gnt, rem_gnt}), 64'(0));
    check("rst_vld", 64'({loc_vld, rem_vld}), 64'(0));
    model_clear();
    @(negedge clk);
    loc_req = '0;
    rem_req = '0;
    cnt_clr = 1'b0;
    rst_n   = 1'b1;
  endtask

  task automatic run_cycle(input logic [NB-1:0] lr, input logic [NB-1:0] rr, input logic clr,
                           input data_t rd0, input tcdm_addr_t a0);
    logic [NB-1:0] lq, rq, eg_l, eg_r;
    data_t rdv [NB];
    @(negedge clk);
    for (int b = 0; b < NB; b++) begin
      if (!l_pend[b]) begin
        la[b] = (b == 0 && a0 != '0) ? a0 : tcdm_addr_t'($urandom);
        lw[b] = 1'($urandom); ld[b] = $urandom; lb[b] = be_t'($urandom);
      end
      if (!r_pend[b]) begin
        ra[b] = tcdm_addr_t'($urandom);
        rw[b] = 1'($urandom); rd[b] = $urandom; rb[b] = be_t'($urandom);
      end
      lq[b] = lr[b] | l_pend[b];
      rq[b] = rr[b] | r_pend[b];
      rdv[b] = (b == 0) ? rd0 : data_t'($urandom);
      loc_req[b] = lq[b]; loc_addr[b] = la[b]; loc_wen[b] = lw[b]; loc_wdata[b] = ld[b]; loc_be[b] = lb[b];
      rem_req[b] = rq[b]; rem_addr[b] = ra[b]; rem_wen[b] = rw[b]; rem_wdata[b] = rd[b]; rem_be[b] = rb[b];
      mem_rdata[b] = rdv[b];
    end
    cnt_clr = clr;
    #1;
    for (int b = 0; b < NB; b++) begin
      logic lwin;
      logic both;
      both = lq[b] & rq[b];
      // Alternation: on a conflict, whoever did not win the previous conflict goes first.
      lwin = both ? !last_loc_won[b] : lq[b];
      eg_l[b] = lq[b] & lwin;
      eg_r[b] = rq[b] & !lwin;
      check("mem_addr", 64'(mem_addr[b]),
            64'(eg_l[b] ? la[b] : (eg_r[b] ? ra[b] : tcdm_addr_t'(0))));
      check("mem_wr", 64'({mem_wen[b], mem_be[b], mem_wdata[b]}),
            64'(eg_l[b] ? {lw[b], lb[b], ld[b]} :
                (eg_r[b] ? {rw[b], rb[b], rd[b]} : 37'(0))));
      check("loc_rsp", 64'({loc_vld[b], loc_rdata[b]}),
            64'((rsp_v[b] && rsp_loc[b]) ? {1'b1, rdv[b]} : 33'(0)));
      check("rem_rsp", 64'({rem_vld[b], rem_rdata[b]}),
            64'((rsp_v[b] && !rsp_loc[b]) ? {1'b1, rdv[b]} : 33'(0)));
      check("cnt", 64'(cnt[b]), exp_cnt(mcnt[b]));
      rsp_v[b]   = lq[b] | rq[b];
      rsp_loc[b] = eg_l[b];
      l_pend[b]  = lq[b] & !eg_l[b];
      r_pend[b]  = rq[b] & !eg_r[b];
      if (both) begin
        last_loc_won[b] = lwin;
        if (mcnt[b] < CntMax) mcnt[b]++;
      end
      if (clr) mcnt[b] = 0;
    end
    check("loc_gnt", 64'(loc_gnt), 64'(eg_l));
    check("rem_gnt", 64'(rem_gnt), 64'(eg_r));
    check("mem_req", 64'(mem_req), 64'(lq | rq));
    last_lg = eg_l;
    last_rg = eg_r;
  endtask

  initial begin
    logic [7:0] gp;
    rst_n   = 1'b0;
    loc_req = '0;
    rem_req = '0;
    cnt_clr = 1'b0;
    for (int b = 0; b < NB; b++) begin
      loc_addr[b] = '0; loc_wen[b] = 1'b0; loc_wdata[b] = '0; loc_be[b] = '0;
      rem_addr[b] = '0; rem_wen[b] = 1'b0; rem_wdata[b] = '0; rem_be[b] = '0;
      mem_rdata[b] = '0;
    end
    model_clear();
    do_reset();

    // Local-only read on bank 0.
    run_cycle(4'b0001, 4'b0000, 1'b0, data_t'($urandom), tcdm_addr_t'(10'h10));
    check("lo_gnt", 64'(loc_gnt[0]), 64'(1));
    check("lo_addr", 64'(mem_addr[0]), 64'(10'h10));
    run_cycle(4'b0000, 4'b0000, 1'b0, 32'hDEADBEEF, '0);
    check("lo_vld", 64'({loc_vld[0], rem_vld[0]}), 64'(2'b10));
    check("lo_rdata", 64'(loc_rdata[0]), 64'(32'hDEADBEEF));

    // Conflict after reset on bank 1: local first, held remote next.
    do_reset();
    run_cycle(4'b0010, 4'b0010, 1'b0, data_t'($urandom), '0);
    check("cf_first", 64'({loc_gnt[1], rem_gnt[1]}), 64'(2'b10));
    run_cycle(4'b0000, 4'b0010, 1'b0, data_t'($urandom), '0);
    check("cf_second", 64'({loc_gnt[1], rem_gnt[1]}), 64'(2'b01));
    check("cf_cnt1", 64'(cnt[1]), exp_cnt(1));
    run_cycle(4'b0000, 4'b0000, 1'b0, data_t'($urandom), '0);
    check("cf_cnt1b", 64'(cnt[1]), exp_cnt(1));

    // Sustained conflict on bank 2.
    do_reset();
    gp = '0;
    for (int i = 0; i < 8; i++) begin
      run_cycle(4'b0100, 4'b0100, 1'b0, data_t'($urandom), '0);
      gp[i] = last_lg[2];
    end
    check("alt_pat", 64'(gp), 64'(8'b0101_0101));
    run_cycle(4'b0000, 4'b0000, 1'b0, data_t'($urandom), '0);
    check("alt_cnt", 64'(cnt[2]), exp_cnt(8));

    // Independence: bank 3 remote-only while bank 0 conflicts.
    do_reset();
    run_cycle(4'b0001, 4'b1001, 1'b0, data_t'($urandom), '0);
    check("ind_b3", 64'({rem_gnt[3], loc_gnt[0], rem_gnt[0]}), 64'(3'b110));
    run_cycle(4'b0000, 4'b1000, 1'b0, data_t'($urandom), '0);
    run_cycle(4'b0001, 4'b1001, 1'b0, data_t'($urandom), '0);
    check("ind_b0", 64'({loc_gnt[0], rem_gnt[0]}), 64'(2'b01));

    // Reset mid-operation drops the in-flight response.
    do_reset();
    run_cycle(4'b0001, 4'b0000, 1'b0, data_t'($urandom), '0);
    do_reset();
    run_cycle(4'b0000, 4'b0000, 1'b0, data_t'($urandom), '0);
    check("mid_novld", 64'({loc_vld, rem_vld}), 64'(0));
    run_cycle(4'b0001, 4'b0001, 1'b0, data_t'($urandom), '0);
    check("mid_loc", 64'({loc_gnt[0], rem_gnt[0]}), 64'(2'b10));

    // Counter saturation and clear-over-increment.
    do_reset();
    for (int i = 0; i < 20; i++) run_cycle(4'b0010, 4'b0010, 1'b0, data_t'($urandom), '0);
    run_cycle(4'b0000, 4'b0000, 1'b0, data_t'($urandom), '0);
    check("sat_cnt", 64'(cnt[1]), exp_cnt(CntMax));
    run_cycle(4'b0010, 4'b0010, 1'b1, data_t'($urandom), '0);
    run_cycle(4'b0000, 4'b0000, 1'b0, data_t'($urandom), '0);
    check("clr_cnt", 64'(cnt[1]), 64'(0));

    // Randomized traffic.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(49) == 0) do_reset();
      run_cycle(NB'($urandom), NB'($urandom), ($urandom_range(15) == 0),
                data_t'($urandom), '0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
